// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, fed LSB first from shift registers,
// with valid/ready handshakes on both the operand and the result side.

module FullAdder (
    input  logic A,
    input  logic B,
    input  logic X,
    output logic S,
    output logic C
);
    assign S = A ^ B ^ X;
    assign C = (A & B) | (X & (A ^ B));
endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_q, sum_nxt;
    logic             carry, cout_q;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_c, last;

    FullAdder u_fa (
        .A (a_sh[0]),
        .B (b_sh[0]),
        .X (carry),
        .S (fa_s),
        .C (fa_c)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    // New sum bit enters at the MSB; written as shift/or so WIDTH=1 needs no slice.
    assign sum_nxt = (sum_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    assign sum  = sum_q;
    assign cout = cout_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs, decoded from the state register only.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand load, bit-serial shifting and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sum_sh <= sum_nxt;
                    carry  <= fa_c;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + CW'(1);
                    // Result is published separately so sum/cout hold until the next completion.
                    if (last) begin
                        sum_q  <= sum_nxt;
                        cout_q <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder of two WIDTH-bit operands plus carry-in, processed LSB first.
- Datapath is exactly one FullAdder instance (A = operand-a bit, B = operand-b bit, X = registered carry, S = sum bit, C = next carry). This block is the sequencing stage that feeds it and consumes its outputs.
- Operands enter through a valid/ready handshake. The result leaves through a valid/ready handshake after WIDTH cycles.
- Trades area for latency where a ripple chain of FullAdders is too large.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..32

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset; asynchronous, active-low
in_valid  input  1  operands a, b, cin valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in
out_valid  output  1  sum/cout valid (high only in DONE)
out_ready  input  1  consumer accepts result
sum  output  WIDTH  a + b + cin, low WIDTH bits
cout  output  1  carry out of bit WIDTH-1

Behaviour:
- State machine has three states.
  - IDLE: in_ready=1.
  - RUN: operation in progress.
  - DONE: out_valid=1.
- Reset (rst_n low, async):
  - State goes to IDLE.
  - Clears the a/b shift regs, the sum shift reg (sum=0), the carry reg, cout=0, out_valid=0 and the bit counter.
  - in_ready=1 once reset releases.
- in_ready and out_valid are decoded directly from the state register. There is no combinational path from any input.
- IDLE, on in_valid & in_ready at edge t:
  - Load the a and b shift regs, set carry=cin, counter=0.
  - Go to RUN.
  - in_valid while not IDLE is ignored. Operand changes after acceptance have no effect.
- RUN, each edge:
  - The FullAdder evaluates a_sh[0], b_sh[0], carry.
  - Shift S into the MSB of the sum shift reg (right shift). After WIDTH shifts, bit 0 holds the LSB result.
  - carry <= C.
  - Right-shift a_sh and b_sh.
  - counter++.
- On the edge where counter reaches WIDTH-1, i.e. the WIDTH-th RUN edge (t+WIDTH):
  - Final sum bit shifted in.
  - cout <= C.
  - Go to DONE.
- Latency: out_valid rises after edge t+WIDTH, i.e. WIDTH cycles after the accepting edge.
- DONE:
  - sum and cout are held stable while out_ready is low (unbounded backpressure).
  - On out_ready at edge u, go to IDLE and drop out_valid. sum and cout keep their values until the next result completes.
  - in_ready rises after edge u. There is no same-cycle accept on the out handshake edge.
  - Throughput: one operation per WIDTH+2 cycles minimum.
- Arithmetic: {cout, sum} == a + b + cin, computed mod 2^(WIDTH+1).
- WIDTH=1: RUN lasts exactly one edge.
- Counter width is clog2(WIDTH)+1. The counter does not wrap within an operation.
- Reset mid-RUN or mid-DONE:
  - Aborts the operation immediately (async). No partial result is presented.
  - Next accept after reset behaves as from cold.
- out_ready is ignored outside DONE.

Test Plan:
- Reset then a=8'h00, b=8'h00, cin=0 -> out_valid exactly 8 cycles after accept; sum=8'h00, cout=0; in_ready=0 throughout RUN/DONE.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1 (carry chain through every bit).
- a=8'h3C, b=8'h5A, cin=0 -> sum=8'h96, cout=0. Hold out_ready=0 for 5 cycles while driving in_valid=1 with a=8'h01, b=8'h01 -> sum/cout stay 8'h96/0, new operands not accepted. Release -> out_valid falls next edge, in_ready rises next edge.
- Deassert rst_n asynchronously on the 3rd RUN cycle of a=8'hAA, b=8'h55 -> out_valid=0, sum=0, cout=0 immediately, in_ready=1 after release. Then a=8'h10, b=8'h20, cin=1 -> sum=8'h31, cout=0.
- WIDTH=1 instance, all 8 combinations of a, b, cin -> out_valid 1 cycle after accept; {cout, sum} matches the full-adder truth table.
- 1000 random back-to-back operations, WIDTH=8, random out_ready stalls -> every result equals a+b+cin, no result dropped or duplicated, accept-to-out_valid gap always 8 cycles.
